// File: rtl/alu_stream_unit.sv
// Streaming 32-bit ALU with result checking, a 2-entry output FIFO
// and saturating operation / mismatch counters.
module alu_stream_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_ctrl,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_check,
  input  logic [31:0]      in_exp_result,
  input  logic [3:0]       in_exp_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic             out_mismatch,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        mm;
  } entry_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [31:0] w_bop;
  logic [32:0] w_sum;
  logic [31:0] w_res;
  logic        w_c;
  logic        w_v;
  logic [3:0]  w_flags;
  logic        w_mm;
  entry_t      w_entry;
  entry_t      w_head;
  logic        w_push;
  logic        w_pop;

  entry_t      r_mem [0:1];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_err_count;

  always_comb begin
    w_bop = (in_ctrl == OP_SUB) ? ~in_b : in_b;
    w_sum = {1'b0, in_a} + {1'b0, w_bop}
          + 33'(in_ctrl == OP_SUB);
    w_res = w_sum[31:0];
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (in_ctrl)
      OP_ADD, OP_SUB: begin
        w_c = w_sum[32];
        w_v = (in_a[31] == w_bop[31])
            && (w_sum[31] != in_a[31]);
      end
      OP_AND: w_res = in_a & in_b;
      OP_OR:  w_res = in_a | in_b;
      default: ;
    endcase
    w_flags = {w_res[31], (w_res == 32'd0), w_c, w_v};
    w_mm    = in_check && ((w_res != in_exp_result)
            || (w_flags != in_exp_flags));
    w_entry = '{res: w_res, flags: w_flags, mm: w_mm};
  end

  // in_ready depends on the registered count only
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = reset && in_valid && in_ready;
  assign w_pop     = reset && out_valid && out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  assign out_result   = out_valid ? w_head.res   : 32'd0;
  assign out_flags    = out_valid ? w_head.flags : 4'd0;
  assign out_mismatch = out_valid && w_head.mm;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear wins over a same-edge increment
  always_ff @(posedge clk) begin
    if (!reset || clr_counts) begin
      r_op_count  <= '0;
      r_err_count <= '0;
    end else if (w_push) begin
      if (r_op_count != '1)
        r_op_count <= r_op_count + CNT_W'(1);
      if (w_mm && (r_err_count != '1))
        r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign op_count  = r_op_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_stream_unit.sv
// Directed, table-driven bench for alu_stream_unit
// plus hand-written backpressure, reset and counter sequences.
module tb_alu_stream_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_ctrl;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          in_check;
  logic [31:0]   in_exp_result;
  logic [3:0]    in_exp_flags;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [3:0]    out_flags;
  logic          out_mismatch;
  logic          clr_counts;
  logic [CW-1:0] op_count;
  logic [CW-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_op   = 0;
  int exp_err  = 0;

  alu_stream_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b),
    .in_check(in_check),
    .in_exp_result(in_exp_result),
    .in_exp_flags(in_exp_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_mismatch(out_mismatch),
    .clr_counts(clr_counts),
    .op_count(op_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        chk;
    logic [31:0] er;
    logic [3:0]  ef;
    logic [31:0] want_r;
    logic [3:0]  want_f;
    logic        want_mm;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic ck,
                       input logic [31:0] er,
                       input logic [3:0] ef);
    in_ctrl = c; in_a = a; in_b = b;
    in_check = ck; in_exp_result = er;
    in_exp_flags = ef;
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'h7FFFFFFF, 32'h1, 1'b0,
                32'h0, 4'h0, 32'h80000000, 4'b1001, 1'b0};
    vecs[1] = '{2'b01, 32'h5, 32'h5, 1'b1,
                32'h0, 4'b0110, 32'h0, 4'b0110, 1'b0};
    vecs[2] = '{2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1,
                32'h0, 4'b0000, 32'h00F000F0, 4'b0000, 1'b1};
    vecs[3] = '{2'b11, 32'h0, 32'h0, 1'b0,
                32'h0, 4'h0, 32'h0, 4'b0100, 1'b0};
    vecs[4] = '{2'b00, 32'hFFFFFFFF, 32'h1, 1'b0,
                32'h0, 4'h0, 32'h0, 4'b0110, 1'b0};
    vecs[5] = '{2'b01, 32'h0, 32'h1, 1'b1,
                32'hFFFFFFFF, 4'b1000, 32'hFFFFFFFF, 4'b1000, 1'b0};
    vecs[6] = '{2'b01, 32'h80000000, 32'h1, 1'b1,
                32'h7FFFFFFF, 4'b0011, 32'h7FFFFFFF, 4'b0011, 1'b0};
    vecs[7] = '{2'b11, 32'h12340000, 32'h00005678, 1'b1,
                32'h12345678, 4'b0001, 32'h12345678, 4'b0000, 1'b1};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clr_counts = 1'b0;
    drive(2'b00, 0, 0, 1'b0, 0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst result", out_result, 0);
    chk("rst flags", 32'(out_flags), 0);
    chk("rst mismatch", 32'(out_mismatch), 0);
    chk("rst op_count", 32'(op_count), 0);
    chk("rst err_count", 32'(err_count), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b,
            vecs[i].chk, vecs[i].er, vecs[i].ef);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_op++;
      if (vecs[i].want_mm) exp_err++;
      chk($sformatf("v%0d valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d result", i), out_result,
          vecs[i].want_r);
      chk($sformatf("v%0d flags", i), 32'(out_flags),
          32'(vecs[i].want_f));
      chk($sformatf("v%0d mm", i), 32'(out_mismatch),
          32'(vecs[i].want_mm));
      chk($sformatf("v%0d op_count", i), 32'(op_count),
          32'(exp_op));
      chk($sformatf("v%0d err_count", i), 32'(err_count),
          32'(exp_err));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d drained", i), 32'(out_valid), 0);
    end

    // backpressure: two fill the FIFO, third waits
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b00, 32'd1, 32'd2, 1'b0, 0, 4'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp ready after 1", 32'(in_ready), 1);
    @(negedge clk);
    drive(2'b00, 32'd3, 32'd4, 1'b0, 0, 4'h0);
    @(posedge clk); #1;
    chk("bp ready after 2", 32'(in_ready), 0);
    @(negedge clk);
    drive(2'b00, 32'd10, 32'd20, 1'b0, 0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp held head", out_result, 32'd3);
    chk("bp held ready", 32'(in_ready), 0);
    chk("bp held op_count", 32'(op_count), 10);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp 2nd head", out_result, 32'd7);
    chk("bp ready freed", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("bp push+pop valid", 32'(out_valid), 1);
    chk("bp 3rd head", out_result, 32'h1E);
    chk("bp op_count", 32'(op_count), 11);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp drained", 32'(out_valid), 0);

    // reset with a full FIFO and a pending request
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre-rst full", 32'(in_ready), 0);
    chk("pre-rst op", 32'(op_count), 13);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid-rst valid", 32'(out_valid), 0);
    chk("mid-rst ready", 32'(in_ready), 1);
    chk("mid-rst op", 32'(op_count), 0);
    chk("mid-rst err", 32'(err_count), 0);
    chk("mid-rst result", out_result, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 32'd2, 32'd2, 1'b0, 0, 4'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post-rst result", out_result, 32'd4);
    chk("post-rst op", 32'(op_count), 1);
    @(posedge clk); #1;

    // saturation and clear priority
    @(negedge clk);
    drive(2'b00, 32'd1, 32'd1, 1'b1, 32'd0, 4'h0);
    in_valid = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("sat op", 32'(op_count), 15);
    chk("sat err", 32'(err_count), 15);
    @(posedge clk); #1;
    chk("sat hold op", 32'(op_count), 15);
    chk("sat hold err", 32'(err_count), 15);
    chk("sat mm", 32'(out_mismatch), 1);
    @(negedge clk);
    clr_counts = 1'b1;
    @(posedge clk); #1;
    chk("clr op", 32'(op_count), 0);
    chk("clr err", 32'(err_count), 0);
    @(negedge clk);
    clr_counts = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("after clr op", 32'(op_count), 1);
    chk("after clr err", 32'(err_count), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("final drained", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
